// File: rtl/jk_drive_sequencer.sv
// Converts a FIFO of desired flop states into one-cycle J/K drive pulses for an external
// JK flop bank, then checks feedback. Define JK_TOGGLE_PREF_EN to resolve don't-cares to 1.
module jk_drive_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic             busy,
    output logic [7:0]       xfer_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_err;
    logic [7:0]       r_xfer;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_present;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign tgt_ready = !rst && !w_full;
    assign w_push    = tgt_valid && tgt_ready;
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_CHECK));
    assign w_head    = r_mem[r_rd_ptr];
    // In CHECK the flops have just updated, so their feedback is the freshest present state.
    assign w_present = (r_state == S_CHECK) ? q_fb : r_sh;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
`ifdef JK_TOGGLE_PREF_EN
            assign w_j[gi] = w_present[gi] | w_head[gi];
            assign w_k[gi] = ~(w_present[gi] & w_head[gi]);
`else
            assign w_j[gi] = ~w_present[gi] & w_head[gi];
            assign w_k[gi] = w_present[gi] & ~w_head[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tgt_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_DRIVE;
            S_DRIVE: w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_empty ? S_IDLE : S_DRIVE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        done = (r_state == S_CHECK);
        busy = (r_state != S_IDLE) || !w_empty;
    end

    // Drive is only ever loaded on a pop, so j/k fall back to 0 (hold) after one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j   <= '0;
            r_k   <= '0;
            r_cur <= '0;
        end else if (w_pop) begin
            r_j   <= w_j;
            r_k   <= w_k;
            r_cur <= w_head;
        end else begin
            r_j   <= '0;
            r_k   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_err  <= 1'b0;
            r_xfer <= '0;
        end else begin
            if (r_state == S_CHECK) begin
                r_sh <= q_fb;
                if (r_xfer != 8'hFF) r_xfer <= r_xfer + 8'd1;
            end
            if ((r_state == S_CHECK) && (q_fb != r_cur)) r_err <= 1'b1;
            else if (err_clr)                           r_err <= 1'b0;
        end
    end

    assign j          = r_j;
    assign k          = r_k;
    assign err        = r_err;
    assign xfer_count = r_xfer;
endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Directed bench for jk_drive_sequencer with a behavioural JK flop bank on j/k/q_fb.
module tb_jk_drive_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic [3:0] tgt_data = 4'h0;
    logic       tgt_ready;
    logic [3:0] j, k, q_fb;
    logic       done, err, busy;
    logic       err_clr = 1'b0;
    logic [7:0] xfer_count;

    logic [3:0] r_q;
    logic [3:0] stuck = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_drive_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(tgt_ready), .j(j), .k(k), .q_fb(q_fb), .done(done),
        .err(err), .err_clr(err_clr), .busy(busy), .xfer_count(xfer_count)
    );

    // External JK flop bank; bits in 'stuck' are forced to 0.
    always @(posedge clk) begin
        if (rst) r_q <= 4'h0;
        else     r_q <= ((j & ~r_q) | (~k & r_q)) & ~stuck;
    end
    assign q_fb = r_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++; if (tgt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", tgt_ready); end
        n_tests++; if (j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL reset_jk: got j=%b k=%b want 0000/0000", j, k); end
        n_tests++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b busy=%b err=%b want 0", done, busy, err); end
        n_tests++; if (xfer_count !== 8'd0) begin n_fail++; $display("FAIL reset_xfer: got %0d want 0", xfer_count); end
        rst = 1'b0;
        tick();
        n_tests++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", tgt_ready); end
    endtask

    task automatic test_transfer(input string name, input logic [3:0] t,
                                 input logic [3:0] ej, input logic [3:0] ek, input logic [7:0] ex);
        tgt_valid = 1'b1; tgt_data = t;
        n_tests++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", name, tgt_ready); end
        tick();
        tgt_valid = 1'b0;
        tick();
        n_tests++; if (j !== ej || k !== ek) begin n_fail++; $display("FAIL %s_drive: got j=%b k=%b want j=%b k=%b", name, j, k, ej, ek); end
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL %s_drive_flags: got done=%b busy=%b want 0/1", name, done, busy); end
        tick();
        n_tests++; if (done !== 1'b1 || q_fb !== t) begin n_fail++; $display("FAIL %s_check: got done=%b q=%b want 1/%b", name, done, q_fb, t); end
        n_tests++; if (j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL %s_check_jk: got j=%b k=%b want 0", name, j, k); end
        $display("[TB] %s: target %b applied, q_fb=%b", name, t, q_fb);
        tick();
        n_tests++; if (xfer_count !== ex || err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_after: got xfer=%0d err=%b done=%b busy=%b want %0d/0/0/0", name, xfer_count, err, done, busy, ex);
        end
    endtask

    task automatic test_single();
`ifdef JK_TOGGLE_PREF_EN
        test_transfer("first", 4'b1010, 4'b1010, 4'b1111, 8'd1);
        test_transfer("second", 4'b0110, 4'b1110, 4'b1101, 8'd2);
`else
        test_transfer("first", 4'b1010, 4'b1010, 4'b0000, 8'd1);
        test_transfer("second", 4'b0110, 4'b0100, 4'b1000, 8'd2);
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0101};
        int idx = 0, ndone = 0, cyc = 0, last = 0;
        bit saw_low = 0, pushing;
        while (ndone < 8 && cyc < 100) begin
            pushing = 0;
            if (idx < 8) begin
                tgt_valid = 1'b1; tgt_data = seq[idx];
                if (tgt_ready) pushing = 1; else saw_low = 1;
            end else tgt_valid = 1'b0;
            if (done) begin
                n_tests++; if (q_fb !== seq[ndone]) begin n_fail++; $display("FAIL b2b_q%0d: got %b want %b", ndone, q_fb, seq[ndone]); end
                if (ndone > 0) begin
                    n_tests++; if (cyc - last != 2) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 2", ndone, cyc - last); end
                end
                $display("[TB] b2b: target %0d done, q_fb=%b", ndone, q_fb);
                last = cyc; ndone++;
            end
            tick();
            cyc++;
            if (pushing) idx++;
        end
        tgt_valid = 1'b0;
        n_tests++; if (ndone != 8) begin n_fail++; $display("FAIL b2b_timeout: got %0d dones want 8", ndone); end
        n_tests++; if (!saw_low) begin n_fail++; $display("FAIL b2b_ready_low: got never-low want low-once"); end
        n_tests++; if (busy !== 1'b0 || xfer_count !== 8'd10) begin n_fail++; $display("FAIL b2b_end: got busy=%b xfer=%0d want 0/10", busy, xfer_count); end
    endtask

    task automatic test_stuck();
        stuck = 4'b0001;
        tick();
        for (int p = 0; p < 2; p++) begin
            tgt_valid = 1'b1; tgt_data = 4'b0001;
            tick();
            tgt_valid = 1'b0;
            tick();
            if (p == 1) begin
                n_tests++; if (j[0] !== 1'b1) begin n_fail++; $display("FAIL stuck_resync_j0: got %b want 1", j[0]); end
            end
            tick();
            n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stuck_done%0d: got %b want 1", p, done); end
            $display("[TB] stuck: push %0d q_fb=%b", p, q_fb);
            tick();
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL stuck_err%0d: got %b want 1", p, err); end
        end
        stuck = 4'b0000;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err); end
        n_tests++; if (xfer_count !== 8'd12) begin n_fail++; $display("FAIL stuck_xfer: got %0d want 12", xfer_count); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq [6] = '{4'b0011, 4'b1100, 4'b0110, 4'b1001, 4'b1111, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            tgt_valid = 1'b1; tgt_data = seq[i];
            tick();
        end
        tgt_valid = 1'b0;
        n_tests++; if ((j | k) === 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_drive: got j=%b k=%b busy=%b want drive/1", j, k, busy); end
        rst = 1'b1;
        tick();
        n_tests++; if (j !== 4'h0 || k !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst: got j=%b k=%b busy=%b done=%b want 0", j, k, busy, done);
        end
        n_tests++; if (xfer_count !== 8'd0 || tgt_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cnt: got xfer=%0d ready=%b want 0/0", xfer_count, tgt_ready); end
        rst = 1'b0;
        tick();
        n_tests++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", tgt_ready); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_quiet%0d: got done=%b busy=%b want 0/0", i, done, busy); end
            tick();
        end
        $display("[TB] reset_mid: queued targets dropped");
    endtask

    task automatic test_saturate();
        int idx = 0, ndone = 0, cyc = 0;
        bit pushing;
        while (ndone < 300 && cyc < 2000) begin
            pushing = 0;
            if (idx < 300) begin
                tgt_valid = 1'b1; tgt_data = idx[0] ? 4'b0010 : 4'b0001;
                pushing = tgt_ready;
            end else tgt_valid = 1'b0;
            if (done) begin
                if (ndone == 256) begin
                    n_tests++; if (xfer_count !== 8'd255) begin n_fail++; $display("FAIL sat_mid: got %0d want 255", xfer_count); end
                end
                ndone++;
            end
            tick();
            cyc++;
            if (pushing) idx++;
        end
        tgt_valid = 1'b0;
        tick();
        n_tests++; if (ndone != 300) begin n_fail++; $display("FAIL sat_timeout: got %0d dones want 300", ndone); end
        n_tests++; if (xfer_count !== 8'd255 || err !== 1'b0) begin n_fail++; $display("FAIL sat_end: got xfer=%0d err=%b want 255/0", xfer_count, err); end
        $display("[TB] saturate: %0d transfers, xfer_count=%0d", ndone, xfer_count);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stuck();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
